// File: rtl/counter_checker_pkg.sv
// Shared types for the counter stream checker.
package counter_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold at all-ones once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/counter_checker.sv
// Monitors an incrementing count stream: locks on, flags mismatches,
// counts errors (saturating) and wrap-arounds, reports loss of lock.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 2,
    parameter int LOSS_CNT   = 2,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic                  locked_o,
    output logic                  error_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic [WRAP_CNT_W-1:0] wrap_cnt_o,
    output logic [WIDTH-1:0]      expected_o
);

    // Wide enough to hold LOCK_CNT-1 / LOSS_CNT-1.
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      exp_q, exp_d;
    logic [GW-1:0]         good_q, good_d;
    logic [BW-1:0]         bad_q, bad_d;
    logic                  locked_q, locked_d;
    logic                  error_q, error_d;
    logic [WRAP_CNT_W-1:0] wrap_q, wrap_d;
    logic                  err_inc;

    // Next-state and status logic; everything holds while enable_i is low.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        bad_d   = bad_q;
        wrap_d  = wrap_q;
        error_d = 1'b0;
        err_inc = 1'b0;
        if (enable_i) begin
            case (state_q)
                IDLE: begin
                    // First sample only seeds the expectation.
                    exp_d   = data_i + WIDTH'(1);
                    good_d  = '0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (data_i == exp_q) begin
                        exp_d = exp_q + WIDTH'(1);
                        if (good_q == GW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else begin
                        // Not locked yet: silently follow the new value.
                        exp_d  = data_i + WIDTH'(1);
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (data_i == exp_q) begin
                        exp_d = exp_q + WIDTH'(1);
                        bad_d = '0;
                        if (data_i == {WIDTH{1'b1}}) begin
                            wrap_d = wrap_q + WRAP_CNT_W'(1);
                        end
                    end else begin
                        error_d = 1'b1;
                        err_inc = 1'b1;
                        if (bad_q == BW'(LOSS_CNT - 1)) begin
                            // Too many misses in a row: drop lock and reseed.
                            state_d = ACQUIRE;
                            exp_d   = data_i + WIDTH'(1);
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            // An isolated glitch keeps the old sequence.
                            bad_d = bad_q + BW'(1);
                            exp_d = exp_q + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            wrap_q   <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            error_q  <= error_d;
            wrap_q   <= wrap_d;
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .inc_i   (err_inc),
        .cnt_o   (err_cnt_o)
    );

    assign locked_o   = locked_q;
    assign error_o    = error_q;
    assign wrap_cnt_o = wrap_q;
    assign expected_o = exp_q;

endmodule
